// File: rtl/mem_access_arbiter.sv
// Shares the single-port data memory between the MIPS MEM stage and the debug unit.
// The pipeline has fixed priority; a bounded-wait counter forces a debug slot, and a dump engine streams all words.
module mem_access_arbiter #(
    parameter int unsigned IO_BUS_SIZE   = 32,
    parameter int unsigned MEM_ADDR_SIZE = 5,
    parameter int unsigned MAX_WAIT      = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_pipe_req,
    input  logic                     i_pipe_wr_rd,
    input  logic [1:0]               i_pipe_wr_src,
    input  logic [2:0]               i_pipe_rd_src,
    input  logic [MEM_ADDR_SIZE-1:0] i_pipe_addr,
    input  logic [IO_BUS_SIZE-1:0]   i_pipe_data,
    output logic [IO_BUS_SIZE-1:0]   o_pipe_rd_data,
    output logic                     o_pipe_stall,
    input  logic                     i_dbg_req,
    input  logic                     i_dbg_wr_rd,
    input  logic [MEM_ADDR_SIZE-1:0] i_dbg_addr,
    input  logic [IO_BUS_SIZE-1:0]   i_dbg_data,
    output logic                     o_dbg_ack,
    output logic [IO_BUS_SIZE-1:0]   o_dbg_rd_data,
    input  logic                     i_dump_start,
    input  logic                     i_dump_ready,
    output logic                     o_dump_valid,
    output logic [IO_BUS_SIZE-1:0]   o_dump_data,
    output logic [MEM_ADDR_SIZE-1:0] o_dump_addr,
    output logic                     o_dump_done,
    output logic                     o_busy,
    output logic                     o_mem_wr_rd,
    output logic [1:0]               o_mem_wr_src,
    output logic [2:0]               o_mem_rd_src,
    output logic [MEM_ADDR_SIZE-1:0] o_mem_addr,
    output logic [IO_BUS_SIZE-1:0]   o_mem_data,
    input  logic [IO_BUS_SIZE-1:0]   i_mem_rd
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        StIdle,
        StSingle,
        StDumpRd,
        StDumpHold,
        StDone
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [WAIT_W-1:0]        r_wait_cnt;
    logic [MEM_ADDR_SIZE-1:0] r_dump_cnt;
    logic                     r_dbg_ack;
    logic [IO_BUS_SIZE-1:0]   r_dbg_rd_data;
    logic [IO_BUS_SIZE-1:0]   r_dump_data;
    logic [MEM_ADDR_SIZE-1:0] r_dump_addr;
    logic                     w_dbg_need;
    logic                     w_grant;

    assign w_dbg_need = (r_state == StSingle) || (r_state == StDumpRd);
    // Forced grant once the debug side has been denied MAX_WAIT times in a row.
    assign w_grant    = w_dbg_need && (!i_pipe_req || (r_wait_cnt == WAIT_W'(MAX_WAIT)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_dump_start) begin
                    w_state_next = StDumpRd;
                end else if (i_dbg_req) begin
                    w_state_next = StSingle;
                end
            end
            StSingle: begin
                if (w_grant) begin
                    w_state_next = StIdle;
                end
            end
            StDumpRd: begin
                if (w_grant) begin
                    w_state_next = StDumpHold;
                end
            end
            StDumpHold: begin
                if (i_dump_ready) begin
                    w_state_next = (r_dump_cnt == LAST_ADDR) ? StDone : StDumpRd;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_dump_valid = (r_state == StDumpHold);
        o_dump_done  = (r_state == StDone);
        o_busy       = (r_state != StIdle);
        o_pipe_stall = w_grant && i_pipe_req;
        o_mem_wr_rd  = i_pipe_wr_rd & i_pipe_req;
        o_mem_wr_src = i_pipe_wr_src;
        o_mem_rd_src = i_pipe_rd_src;
        o_mem_addr   = i_pipe_addr;
        o_mem_data   = i_pipe_data;
        if (w_grant) begin
            o_mem_wr_src = 2'b00;
            o_mem_rd_src = 3'b000;
            if (r_state == StSingle) begin
                o_mem_wr_rd = i_dbg_wr_rd;
                o_mem_addr  = i_dbg_addr;
                o_mem_data  = i_dbg_data;
            end else begin
                o_mem_wr_rd = 1'b0;
                o_mem_addr  = r_dump_cnt;
                o_mem_data  = '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt    <= '0;
            r_dump_cnt    <= '0;
            r_dbg_ack     <= 1'b0;
            r_dbg_rd_data <= '0;
            r_dump_data   <= '0;
            r_dump_addr   <= '0;
        end else begin
            if (w_dbg_need && !w_grant) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            if ((r_state == StIdle) && i_dump_start) begin
                r_dump_cnt <= '0;
            end else if ((r_state == StDumpHold) && i_dump_ready && (r_dump_cnt != LAST_ADDR)) begin
                r_dump_cnt <= r_dump_cnt + MEM_ADDR_SIZE'(1);
            end

            r_dbg_ack <= (r_state == StSingle) && w_grant;
            if ((r_state == StSingle) && w_grant) begin
                r_dbg_rd_data <= i_dbg_wr_rd ? i_dbg_data : i_mem_rd;
            end

            if ((r_state == StDumpRd) && w_grant) begin
                r_dump_data <= i_mem_rd;
                r_dump_addr <= r_dump_cnt;
            end
        end
    end

    assign o_dbg_ack      = r_dbg_ack;
    assign o_dbg_rd_data  = r_dbg_rd_data;
    assign o_dump_data    = r_dump_data;
    assign o_dump_addr    = r_dump_addr;
    assign o_pipe_rd_data = i_mem_rd;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: behavioural memory, debug/dump scoreboards.
module tb_mem_access_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int MW    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_init = 1'b0;
    logic          pipe_req = 1'b0;
    logic          pipe_wr_rd = 1'b0;
    logic [1:0]    pipe_wr_src = 2'b00;
    logic [2:0]    pipe_rd_src = 3'b000;
    logic [AW-1:0] pipe_addr = '0;
    logic [DW-1:0] pipe_data = '0;
    logic [DW-1:0] pipe_rd_data;
    logic          pipe_stall;
    logic          dbg_req = 1'b0;
    logic          dbg_wr_rd = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data = '0;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rd_data;
    logic          dump_start = 1'b0;
    logic          dump_ready = 1'b0;
    logic          dump_valid;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_addr;
    logic          dump_done;
    logic          busy;
    logic          mem_wr_rd;
    logic [1:0]    mem_wr_src;
    logic [2:0]    mem_rd_src;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_rd;
    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0]    q_dbg[$];
    logic [AW+DW-1:0] q_dump[$];

    mem_access_arbiter #(
        .IO_BUS_SIZE  (DW),
        .MEM_ADDR_SIZE(AW),
        .MAX_WAIT     (MW)
    ) u_dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_pipe_req    (pipe_req),
        .i_pipe_wr_rd  (pipe_wr_rd),
        .i_pipe_wr_src (pipe_wr_src),
        .i_pipe_rd_src (pipe_rd_src),
        .i_pipe_addr   (pipe_addr),
        .i_pipe_data   (pipe_data),
        .o_pipe_rd_data(pipe_rd_data),
        .o_pipe_stall  (pipe_stall),
        .i_dbg_req     (dbg_req),
        .i_dbg_wr_rd   (dbg_wr_rd),
        .i_dbg_addr    (dbg_addr),
        .i_dbg_data    (dbg_data),
        .o_dbg_ack     (dbg_ack),
        .o_dbg_rd_data (dbg_rd_data),
        .i_dump_start  (dump_start),
        .i_dump_ready  (dump_ready),
        .o_dump_valid  (dump_valid),
        .o_dump_data   (dump_data),
        .o_dump_addr   (dump_addr),
        .o_dump_done   (dump_done),
        .o_busy        (busy),
        .o_mem_wr_rd   (mem_wr_rd),
        .o_mem_wr_src  (mem_wr_src),
        .o_mem_rd_src  (mem_rd_src),
        .o_mem_addr    (mem_addr),
        .o_mem_data    (mem_data),
        .i_mem_rd      (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | DW'(i);
        end else if (mem_wr_rd) begin
            mem[mem_addr] <= mem_data;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ack"}, 64'(dbg_ack), 0);
        check_eq({tag, "_dbg_rd_data"}, 64'(dbg_rd_data), 0);
        check_eq({tag, "_dump_valid"}, 64'(dump_valid), 0);
        check_eq({tag, "_dump_data"}, 64'(dump_data), 0);
        check_eq({tag, "_dump_addr"}, 64'(dump_addr), 0);
        check_eq({tag, "_dump_done"}, 64'(dump_done), 0);
        check_eq({tag, "_busy"}, 64'(busy), 0);
        check_eq({tag, "_stall"}, 64'(pipe_stall), 0);
    endtask

    // pipe_req is dropped at loop iteration pipe_hold; iteration 0 is the IDLE cycle.
    task automatic dbg_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [DW-1:0] exp_rd, input int pipe_hold,
                              input int exp_busy, input int exp_stall);
        int busy_n  = 0;
        int stall_n = 0;
        int deny_n  = 0;
        bit got     = 1'b0;
        q_dbg.push_back(exp_rd);
        dbg_wr_rd = wr;
        dbg_addr  = addr;
        dbg_data  = data;
        dbg_req   = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (i == pipe_hold) pipe_req = 1'b0;
            @(negedge clk);
            if (pipe_stall) begin
                stall_n++;
                check_eq("stall_mem_addr", 64'(mem_addr), 64'(addr));
            end else if (pipe_req) begin
                check_eq("pipe_owns_addr", 64'(mem_addr), 64'(pipe_addr));
            end
            if (busy) busy_n++;
            if (busy && !pipe_stall && pipe_req) deny_n++;
            if (dbg_ack) begin
                got     = 1'b1;
                dbg_req = 1'b0;
                check_eq("dbg_rd_data", 64'(dbg_rd_data), 64'(q_dbg.pop_front()));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        dbg_req = 1'b0;
        check_eq("dbg_ack_seen", 64'(got), 1);
        if (!got) q_dbg.delete();
        check_eq("dbg_busy_cycles", 64'(busy_n), 64'(exp_busy));
        check_eq("dbg_stall_cycles", 64'(stall_n), 64'(exp_stall));
        if (exp_stall != 0) check_eq("dbg_denied_cycles", 64'(deny_n), 64'(MW));
        @(negedge clk);
        check_eq("dbg_ack_pulse", 64'(dbg_ack), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_dump(input bit rand_ready, input bit abort, input logic [AW-1:0] abort_addr);
        int acc      = 0;
        int last_acc = -10;
        bit done     = 1'b0;
        bit aborted  = 1'b0;
        bit prev_hold = 1'b0;
        logic [AW+DW-1:0] prev = '0;
        logic [AW+DW-1:0] exp;
        q_dump.delete();
        for (int i = 0; i < DEPTH; i++) q_dump.push_back({AW'(i), DW'(i) * 32'h0101_0101});
        dump_start = 1'b1;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
        for (int c = 0; c < 400 && !done && !aborted; c++) begin
            dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_hold) begin
                check_eq("dump_stable", 64'({dump_valid, dump_addr, dump_data}), 64'({1'b1, prev}));
            end
            prev_hold = dump_valid && !dump_ready;
            prev      = {dump_addr, dump_data};
            if (abort && dump_valid && dump_addr == abort_addr) begin
                rst = 1'b1;
                #1;
                check_idle_outputs("abort");
                @(posedge clk);
                #1;
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check_eq("abort_no_done", 64'(dump_done), 0);
                end
                @(posedge clk);
                #1;
                aborted = 1'b1;
            end else begin
                if (dump_valid && dump_ready) begin
                    check_eq("dump_extra_word", 64'(q_dump.size() == 0), 0);
                    if (q_dump.size() != 0) begin
                        exp = q_dump.pop_front();
                        check_eq("dump_addr", 64'(dump_addr), 64'(exp[AW+DW-1:DW]));
                        check_eq("dump_data", 64'(dump_data), 64'(exp[DW-1:0]));
                    end
                    acc++;
                    last_acc = c;
                end
                if (dump_done) begin
                    done = 1'b1;
                    check_eq("dump_word_count", 64'(acc), 64'(DEPTH));
                    check_eq("dump_done_timing", 64'(c), 64'(last_acc + 1));
                end
                @(posedge clk);
                #1;
            end
        end
        dump_ready = 1'b0;
        if (!abort) begin
            check_eq("dump_done_seen", 64'(done), 1);
            @(negedge clk);
            check_eq("dump_done_pulse", 64'(dump_done), 0);
            @(posedge clk);
            #1;
        end else begin
            check_eq("dump_aborted", 64'(aborted), 1);
        end
    endtask

    initial begin
        #1;
        rst      = 1'b1;
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        mem_init = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;

        // Uncontested debug write then read back.
        dbg_access(1'b1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 0);
        dbg_access(1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);

        // Pipeline busy forever: forced grant after MAX_WAIT denials.
        pipe_req   = 1'b1;
        pipe_wr_rd = 1'b0;
        pipe_addr  = 5'd0;
        dbg_access(1'b0, 5'd3, 32'h0, 32'hA500_0003, 1000, MW + 1, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("no_extra_stall", 64'(pipe_stall), 0);
        end
        @(posedge clk);
        #1;

        // Pipeline write wins while debug waits, then debug sees it.
        pipe_req   = 1'b1;
        pipe_wr_rd = 1'b1;
        pipe_addr  = 5'd7;
        pipe_data  = 32'h1234_5678;
        dbg_access(1'b0, 5'd7, 32'h0, 32'h1234_5678, 3, 3, 0);
        pipe_wr_rd = 1'b0;

        // Fill memory through the pipeline port.
        for (int i = 0; i < DEPTH; i++) begin
            pipe_req   = 1'b1;
            pipe_wr_rd = 1'b1;
            pipe_addr  = AW'(i);
            pipe_data  = DW'(i) * 32'h0101_0101;
            @(posedge clk);
            #1;
        end
        pipe_req   = 1'b0;
        pipe_wr_rd = 1'b0;
        dbg_access(1'b0, 5'd31, 32'h0, 32'h1F1F_1F1F, 0, 1, 0);

        run_dump(1'b0, 1'b0, '0);
        run_dump(1'b1, 1'b0, '0);
        run_dump(1'b0, 1'b1, 5'd10);
        run_dump(1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Arbiter and sequencer that shares the single-port MIPS data memory (MEM stage) between the pipeline and the debug unit. The pipeline gets fixed priority, with a bounded-wait starvation guard for debug. The block also runs an autonomous full-memory dump sequence for the debugger. It sits between the MEM stage control signals and the data memory's write/read-source and address inputs.

## Interface
- IO_BUS_SIZE, 32, data word width
- MEM_ADDR_SIZE, 5, word address width; memory depth is 2**MEM_ADDR_SIZE
- MAX_WAIT, 8, cycles a pending debug request may be denied before the pipeline is stalled
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_pipe_req  in  1  pipeline memory operation valid this cycle
- i_pipe_wr_rd  in  1  1 = write, 0 = read
- i_pipe_wr_src  in  2  write size code, passed through
- i_pipe_rd_src  in  3  read size/sign code, passed through
- i_pipe_addr  in  MEM_ADDR_SIZE  pipeline address
- i_pipe_data  in  IO_BUS_SIZE  pipeline write data
- o_pipe_rd_data  out  IO_BUS_SIZE  memory read data for the pipeline (combinational)
- o_pipe_stall  out  1  pipeline must hold its MEM request this cycle
- i_dbg_req  in  1  single debug access request; level, held until o_dbg_ack
- i_dbg_wr_rd  in  1  1 = write, 0 = read
- i_dbg_addr  in  MEM_ADDR_SIZE  debug address
- i_dbg_data  in  IO_BUS_SIZE  debug write data
- o_dbg_ack  out  1  one-cycle pulse; the debug access is complete
- o_dbg_rd_data  out  IO_BUS_SIZE  registered read data, valid with o_dbg_ack
- i_dump_start  in  1  pulse; dump addresses 0..2**MEM_ADDR_SIZE-1
- i_dump_ready  in  1  consumer accepts o_dump_data
- o_dump_valid  out  1  o_dump_data/o_dump_addr valid
- o_dump_data  out  IO_BUS_SIZE  dumped word
- o_dump_addr  out  MEM_ADDR_SIZE  address of dumped word
- o_dump_done  out  1  one-cycle pulse after the last word is accepted
- o_busy  out  1  a debug access or dump is in progress
- o_mem_wr_rd, o_mem_wr_src[1:0], o_mem_rd_src[2:0], o_mem_addr, o_mem_data  out  memory control, address and write data (combinational mux)
- i_mem_rd  in  IO_BUS_SIZE  memory read data (asynchronous read)

## Operation
- FSM states:
  - IDLE: debug side idle.
  - SINGLE: i_dbg_req pending.
  - DUMP_RD: the dump needs a memory slot.
  - DUMP_HOLD: o_dump_valid is high, waiting for i_dump_ready.
  - DONE: asserts o_dump_done for one cycle, then returns to IDLE.
- IDLE transitions:
  - i_dump_start takes precedence over i_dbg_req and moves to DUMP_RD with the address counter at 0.
  - Otherwise i_dbg_req moves to SINGLE.
  - Requests arriving in any non-IDLE state are ignored. The i_dbg_req level is re-sampled on return to IDLE.
- Debug needs a slot in SINGLE and DUMP_RD. A slot is granted when:
  - i_pipe_req = 0; or
  - wait_cnt == MAX_WAIT (forced grant). In this case o_pipe_stall = 1 if i_pipe_req = 1.
- wait_cnt increments each cycle the debug side needs a slot and is denied. It clears on every grant and in IDLE/DUMP_HOLD. Saturation is not needed because it is bounded by MAX_WAIT.
- Pipeline owns memory whenever debug is not granted. o_mem_* mirror the pipe inputs, and o_mem_wr_rd = i_pipe_wr_rd & i_pipe_req.
- Debug grant cycle drives the memory from the debug side:
  - SINGLE: o_mem_wr_src = 2'b00 (word), o_mem_rd_src = 3'b000 (word), o_mem_addr = i_dbg_addr, o_mem_data = i_dbg_data, o_mem_wr_rd = i_dbg_wr_rd.
  - Dump: read only, o_mem_wr_rd = 0.
- SINGLE grant: i_mem_rd is registered into o_dbg_rd_data (write data for writes), and o_dbg_ack = 1 next cycle. The state returns to IDLE in the same edge.
- DUMP_RD grant: i_mem_rd is captured into o_dump_data, the counter into o_dump_addr, and the state moves to DUMP_HOLD.
- DUMP_HOLD, cycle with i_dump_ready = 1:
  - If the address equals 2**MEM_ADDR_SIZE-1, go to DONE.
  - Otherwise increment the address and go to DUMP_RD.
- Address wrap: the counter is MEM_ADDR_SIZE bits and is never incremented past the last address.
- o_pipe_rd_data = i_mem_rd always; it is meaningful only when the pipeline is not stalled.

## Timing
- Reset (async) values:
  - All outputs 0, except that o_mem_* follow the pipe mux because they are combinational.
  - State IDLE, wait_cnt = 0, dump counter 0.
  - Reset during a dump aborts it with no o_dump_done.
- Pipeline access: 0-cycle latency, combinational through the mux.
- Single debug access, uncontested:
  - i_dbg_req rises at edge N and is seen in IDLE at edge N+1, which enters SINGLE.
  - The grant cycle is N+1..N+2 and o_dbg_ack is high N+2..N+3.
  - Worst case adds MAX_WAIT cycles.
- Dump word: minimum 2 cycles per word (DUMP_RD + DUMP_HOLD with ready held high). A full dump takes at least 2·2**MEM_ADDR_SIZE + 1 cycles.
- o_pipe_stall is combinational and asserted for exactly one cycle per forced grant.

## Test plan
- Reset, then debug write 0xDEADBEEF to addr 5 with i_pipe_req = 0 → o_dbg_ack for one cycle. A debug read of addr 5 then returns o_dbg_rd_data = 0xDEADBEEF.
- i_pipe_req held at 1 continuously, debug read of addr 3 → exactly 8 denied cycles, then one cycle with o_pipe_stall = 1 and o_mem_addr = 3, then o_dbg_ack. No other stall cycles occur.
- Pipeline write 0x12345678 to addr 7 with a debug request pending → the pipeline write lands; debug is not granted until the pipeline idles or the counter expires.
- Fill addrs 0..31 with value = addr·0x01010101, then dump with i_dump_ready always 1 → 32 valid words in order, correct data, o_dump_done one cycle after addr 31.
- Dump with i_dump_ready toggling randomly → o_dump_data/o_dump_addr are stable while valid and not ready; no word is skipped or duplicated.
- Assert i_reset mid-dump at addr 10 → all outputs 0 immediately and no o_dump_done. A new i_dump_start restarts from addr 0.
